// File: rtl/medio_sumador_pkg.sv
// Shared constants for the ripple half/full adder block: default widths and
// the carry-event counter saturation value.
package medio_sumador_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 16;

    // All-ones value for a counter of width w (w up to 64).
    function automatic logic [63:0] cnt_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/celda_medio_sumador.sv
// One-bit half-adder cell; every adder bit of the ripple chain is built from these.
module celda_medio_sumador (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/medio_sumador.sv
// Ripple-carry adder with a combinational sum, a registered copy of the last
// captured result, a one-cycle valid delay and a saturating carry-event counter.
module medio_sumador
    import medio_sumador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             valida_ent,
    output logic [WIDTH-1:0] Salida,
    output logic             CarrieSalida,
    output logic [WIDTH-1:0] Salida_reg,
    output logic             CarrieSalida_reg,
    output logic             valida_sal,
    output logic [CNT_W-1:0] cuenta_carry
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    // carry[i] is the carry into bit i (and carry[WIDTH] the carry-out).
    logic [WIDTH:1]   carry;
    logic [WIDTH-1:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_ha
                celda_medio_sumador u_ha (
                    .a(X[0]),
                    .b(Y[0]),
                    .s(sum[0]),
                    .c(carry[1])
                );
            end else begin : g_fa
                logic p, g1, g2;
                celda_medio_sumador u_ha0 (
                    .a(X[gi]),
                    .b(Y[gi]),
                    .s(p),
                    .c(g1)
                );
                celda_medio_sumador u_ha1 (
                    .a(p),
                    .b(carry[gi]),
                    .s(sum[gi]),
                    .c(g2)
                );
                assign carry[gi+1] = g1 | g2;
            end
        end
    endgenerate

    assign Salida       = sum;
    assign CarrieSalida = carry[WIDTH];

    // Release is re-timed through two flops so that no register loads on the
    // edge that coincides with rst_n rising.
    logic [1:0] sync_reg;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign run = sync_reg[1];

    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (run) begin
            valid_reg <= valida_ent;
            if (valida_ent) begin
                sum_reg   <= sum;
                carry_reg <= carry[WIDTH];
                if (carry[WIDTH] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign Salida_reg       = sum_reg;
    assign CarrieSalida_reg = carry_reg;
    assign valida_sal       = valid_reg;
    assign cuenta_carry     = cnt_reg;

endmodule

// File: tb/tb_medio_sumador.sv
// Scoreboard bench for medio_sumador: a 1-bit instance and a 4-bit instance
// with a 2-bit counter, driven by directed vectors.
module tb_medio_sumador;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        x1, y1, ve1;
    logic        s1, c1, sr1, cr1, vs1;
    logic [15:0] cnt1;

    logic [3:0]  x4, y4;
    logic        ve4;
    logic [3:0]  s4, sr4;
    logic        c4, cr4, vs4;
    logic [1:0]  cnt4;

    medio_sumador #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .X(x1), .Y(y1), .valida_ent(ve1),
        .Salida(s1), .CarrieSalida(c1), .Salida_reg(sr1),
        .CarrieSalida_reg(cr1), .valida_sal(vs1), .cuenta_carry(cnt1)
    );

    medio_sumador #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .X(x4), .Y(y4), .valida_ent(ve4),
        .Salida(s4), .CarrieSalida(c4), .Salida_reg(sr4),
        .CarrieSalida_reg(cr4), .valida_sal(vs4), .cuenta_carry(cnt4)
    );

    typedef struct packed {
        logic [3:0]  s;
        logic        c;
        logic [15:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected result whenever the DUT flags valida_sal.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (vs1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon1_unexpected: valida_sal got 1 expected 0");
            end else begin
                e = q1.pop_front();
                chk("mon1_sum_reg",   32'(sr1),  32'(e.s[0]));
                chk("mon1_carry_reg", 32'(cr1),  32'(e.c));
                chk("mon1_cuenta",    32'(cnt1), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (vs4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon4_unexpected: valida_sal got 1 expected 0");
            end else begin
                e = q4.pop_front();
                chk("mon4_sum_reg",   32'(sr4),  32'(e.s));
                chk("mon4_carry_reg", 32'(cr4),  32'(e.c));
                chk("mon4_cuenta",    32'(cnt4), 32'(e.cnt));
            end
        end
    end

    // Call at a falling edge: present a capture for one rising edge.
    task automatic cap1(input logic x, input logic y, input logic es, input logic ec,
                        input logic [15:0] ecnt);
        exp_t e;
        x1 = x;
        y1 = y;
        ve1 = 1'b1;
        #1;
        chk("cap1_comb_sum",   32'(s1), 32'(es));
        chk("cap1_comb_carry", 32'(c1), 32'(ec));
        e.s = {3'b000, es};
        e.c = ec;
        e.cnt = ecnt;
        q1.push_back(e);
        @(negedge clk);
        ve1 = 1'b0;
    endtask

    task automatic cap4(input logic [3:0] x, input logic [3:0] y, input logic [3:0] es,
                        input logic ec, input logic [1:0] ecnt);
        exp_t e;
        x4 = x;
        y4 = y;
        ve4 = 1'b1;
        #1;
        chk("cap4_comb_sum",   32'(s4), 32'(es));
        chk("cap4_comb_carry", 32'(c4), 32'(ec));
        e.s = es;
        e.c = ec;
        e.cnt = {14'd0, ecnt};
        q4.push_back(e);
        @(negedge clk);
        ve4 = 1'b0;
    endtask

    logic [3:0] tt_s = 4'b0110;
    logic [3:0] tt_c = 4'b1000;

    initial begin
        x1 = 1'b0; y1 = 1'b0; ve1 = 1'b0;
        x4 = 4'h0; y4 = 4'h0; ve4 = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_sum_reg4",   32'(sr4),  32'd0);
        chk("rst_carry_reg4", 32'(cr4),  32'd0);
        chk("rst_valida4",    32'(vs4),  32'd0);
        chk("rst_cuenta4",    32'(cnt4), 32'd0);
        chk("rst_cuenta1",    32'(cnt1), 32'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Half-adder truth table, 10 ns per vector.
        for (int i = 0; i < 4; i++) begin
            x1 = i[1];
            y1 = i[0];
            #1;
            chk("tt_salida",       32'(s1), 32'(tt_s[i]));
            chk("tt_carriesalida", 32'(c1), 32'(tt_c[i]));
            #9;
        end
        @(negedge clk);

        cap1(1'b1, 1'b1, 1'b0, 1'b1, 16'd1);
        cap1(1'b1, 1'b0, 1'b1, 1'b0, 16'd1);

        // Five carry-producing captures on a 2-bit counter: 1,2,3,3,3.
        cap4(4'h7, 4'h8, 4'hF, 1'b0, 2'd0);
        cap4(4'hF, 4'h1, 4'h0, 1'b1, 2'd1);
        cap4(4'h8, 4'h8, 4'h0, 1'b1, 2'd2);
        cap4(4'hF, 4'hF, 4'hE, 1'b1, 2'd3);
        cap4(4'h9, 4'h7, 4'h0, 1'b1, 2'd3);
        cap4(4'hC, 4'h4, 4'h0, 1'b1, 2'd3);

        // Operands toggle without valida_ent: registered outputs hold.
        for (int i = 0; i < 5; i++) begin
            x4 = 4'(i + 8);
            y4 = 4'hF - 4'(i);
            @(negedge clk);
            chk("hold_sum_reg",   32'(sr4),  32'h0);
            chk("hold_carry_reg", 32'(cr4),  32'd1);
            chk("hold_cuenta",    32'(cnt4), 32'd3);
            chk("hold_valida",    32'(vs4),  32'd0);
        end

        cap4(4'h3, 4'h4, 4'h7, 1'b0, 2'd3);

        // Reset between edges with a capture pending.
        x4 = 4'h9;
        y4 = 4'h9;
        ve4 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum_reg4",   32'(sr4),  32'd0);
        chk("arst_carry_reg4", 32'(cr4),  32'd0);
        chk("arst_valida4",    32'(vs4),  32'd0);
        chk("arst_cuenta4",    32'(cnt4), 32'd0);
        chk("arst_cuenta1",    32'(cnt1), 32'd0);
        chk("arst_comb_sum",   32'(s4),   32'h2);
        chk("arst_comb_carry", 32'(c4),   32'd1);

        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_valida4", 32'(vs4),  32'd0);
        chk("release_cuenta4", 32'(cnt4), 32'd0);
        chk("release_sum_reg", 32'(sr4),  32'd0);
        ve4 = 1'b0;
        repeat (3) @(negedge clk);

        cap4(4'hF, 4'h1, 4'h0, 1'b1, 2'd1);
        cap4(4'h5, 4'h6, 4'hB, 1'b0, 2'd1);
        @(negedge clk);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/medio_sumador.md
MEDIO_SUMADOR -- requirements
Module: medio_sumador

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter.
REQ-003 clk  input  1: single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 X  input  WIDTH: operand A.
REQ-006 Y  input  WIDTH: operand B.
REQ-007 valida_ent  input  1: operands valid this cycle; capture request.
REQ-008 Salida  output  WIDTH: combinational sum, (X+Y) mod 2^WIDTH.
REQ-009 CarrieSalida  output  1: combinational carry-out of X+Y.
REQ-010 Salida_reg  output  WIDTH: registered sum of last captured operands.
REQ-011 CarrieSalida_reg  output  1: registered carry of last captured operands.
REQ-012 valida_sal  output  1: registered outputs updated in the previous edge.
REQ-013 cuenta_carry  output  CNT_W: number of captured operations that produced carry.

Function
REQ-014 Salida and CarrieSalida SHALL be purely combinational from X, Y; no clock or reset dependency, zero latency.
REQ-015 WIDTH=1 SHALL yield the half-adder truth table: Salida = X xor Y, CarrieSalida = X and Y.
REQ-016 WIDTH>1: {CarrieSalida, Salida} SHALL equal the (WIDTH+1)-bit unsigned sum of X and Y, with no carry-in.
REQ-017 Sum SHALL be built as a ripple chain: bit 0 a half-adder cell, bits 1..WIDTH-1 full-adder cells (two half-adder cells plus OR).
REQ-018 On a rising edge with valida_ent=1, Salida_reg/CarrieSalida_reg SHALL load the current combinational Salida/CarrieSalida; latency exactly one cycle.
REQ-019 With valida_ent=0, Salida_reg/CarrieSalida_reg SHALL hold their value.
REQ-020 valida_sal SHALL equal valida_ent delayed by one clock.
REQ-021 cuenta_carry SHALL increment by 1 on each edge where valida_ent=1 and CarrieSalida=1.
REQ-022 cuenta_carry SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-023 Operand changes between edges SHALL NOT affect registered outputs until the next qualifying edge.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, clear Salida_reg, CarrieSalida_reg, valida_sal and cuenta_carry to 0.
REQ-025 Reset asserted mid-operation SHALL discard the pending capture; the first valid capture after deassertion behaves as REQ-018.
REQ-026 Combinational outputs SHALL remain functional during reset.
REQ-027 Deassertion SHALL be sampled so that no register updates on the edge coinciding with release.

Structure
REQ-028 A shared package SHALL hold default WIDTH and CNT_W constants and the counter saturation value.
REQ-029 One sub-module, celda_medio_sumador (1-bit: a, b -> s, c), SHALL be instantiated for every half-adder cell.
REQ-030 Top level contains only the ripple generate loop, output registers, valid delay and counter.

Verification
REQ-031 WIDTH=1, X/Y = 00,01,10,11 held 10 ns each -> Salida 0,1,1,0 and CarrieSalida 0,0,0,1 within the same time step.
REQ-032 WIDTH=1, valida_ent=1 with X=1,Y=1 on one edge -> next cycle Salida_reg=0, CarrieSalida_reg=1, valida_sal=1, cuenta_carry=1.
REQ-033 WIDTH=4, X=4'hF, Y=4'h1 -> Salida=4'h0, CarrieSalida=1; X=4'h7, Y=4'h8 -> Salida=4'hF, CarrieSalida=0.
REQ-034 rst_n pulled low between clock edges after captures -> all registered outputs 0 immediately; combinational outputs unchanged.
REQ-035 CNT_W=2, five carry-producing captures -> cuenta_carry reads 1,2,3,3,3.
REQ-036 valida_ent=0 while operands toggle for 5 cycles -> Salida_reg, CarrieSalida_reg, cuenta_carry unchanged; valida_sal=0.
